calc_controller: RTL and testbench
==================================

CALC_CONTROLLER -- requirements
Module: calc_controller

Interface
REQ-001 Parameter DIGITS, default 4: maximum decimal digits per operand.
REQ-002 Parameter RW, default 27: result width; SHALL hold (10^DIGITS-1)^2.
REQ-003 clk  input  1  system clock (12 MHz board clock).
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 key_code  input  6  debounced key code: 0-9 digit, 10 '+', 11 '-', 12 '=', 13 '*', 14 clear, 15 '/', 16 no key.
REQ-006 disp_val  output  RW  unsigned binary value to display.
REQ-007 op_pending  output  2  latched operator: 0 '+', 1 '-', 2 '*', 3 '/'.
REQ-008 busy  output  1  high while the iterative divide runs.
REQ-009 err  output  1  high in ERROR state.
REQ-010 key_evt  output  1  one-cycle pulse per accepted key event.

Function
REQ-011 Key event: key_code != 16 in the current cycle while the registered previous code == 16; held keys SHALL produce exactly one event; a code change without passing through 16 SHALL produce no event.
REQ-012 key_evt SHALL assert in the cycle after the qualifying key_code sample.
REQ-013 States: ENTER_A, ENTER_B, DIVIDE, SHOW, ERROR; reset state ENTER_A.
REQ-014 Digit in ENTER_A/ENTER_B: operand = operand*10 + digit, but only if the operand holds fewer than DIGITS digits; excess digits SHALL be ignored, with no error. Leading zeros do not count toward DIGITS.
REQ-015 Operator in ENTER_A: latch op_pending, clear B, go to ENTER_B. Operator in ENTER_B: replace op_pending and stay in ENTER_B; B is unchanged.
REQ-016 '=' in ENTER_A: result = A, go to SHOW. '=' in ENTER_B with '+', '-' or '*': compute the result in one cycle and go to SHOW.
REQ-017 '=' with '/' and B != 0: go to DIVIDE. A restoring divider SHALL run one quotient bit per cycle for exactly 16 cycles, then go to SHOW with result = floor(A/B).
REQ-018 '=' with '/' and B == 0: go to ERROR. '=' with '-' and A < B: go to ERROR.
REQ-019 DIVIDE: busy=1 and all key events are ignored, including clear.
REQ-020 SHOW: a digit loads A=digit and goes to ENTER_A. An operator with result < 10^DIGITS loads A=result, latches the operator and goes to ENTER_B. An operator with result >= 10^DIGITS goes to ERROR. '=' is ignored.
REQ-021 ERROR: err=1 and disp_val=0. Only clear is accepted.
REQ-022 Clear in any state except DIVIDE: A=B=result=0, op_pending=0, go to ENTER_A.
REQ-023 disp_val SHALL be registered: A in ENTER_A, B in ENTER_B, result in SHOW, the last B in DIVIDE.
REQ-024 Arithmetic is unsigned. The '*' product SHALL be RW bits wide with no truncation.

Reset
REQ-025 rst_n low SHALL asynchronously set: state ENTER_A, A=B=result=0, previous key code 16, divider counter 0, disp_val=0, op_pending=0, busy=0, err=0, key_evt=0.
REQ-026 Reset asserted mid-DIVIDE SHALL abort the divide with no residual busy.

Structure
REQ-027 A shared package SHALL hold the key-code constants (KEY_NONE=16, KEY_ADD=10, KEY_SUB=11, KEY_EQ=12, KEY_MUL=13, KEY_CLR=14, KEY_DIV=15), the state encoding and the op_pending encoding.
REQ-028 The iterative divider SHALL be one sub-module, seq_divider, with a start/done handshake: start is a one-cycle pulse and done is a one-cycle pulse after 16 cycles.
REQ-029 No other sub-modules; the edge detect, digit accumulation and FSM stay in calc_controller.

Verification
REQ-030 Key sequence 1,2,'+',3,4,'=', each press separated by a 16 code: disp_val=46 in SHOW, op_pending=0, key_evt pulsed six times.
REQ-031 Key sequence 9,9,9,9,'*',9,9,9,9,'=': disp_val=99980001. A fifth digit 9 entered before the operator is ignored and disp_val stays 9999.
REQ-032 Key sequence 1,0,0,'/',7,'=': busy high exactly 16 cycles, then disp_val=14; key '5' pressed during busy is ignored.
REQ-033 Key sequences 5,'/',0,'=' and 3,'-',8,'=': err=1 and disp_val=0 in each case; a following clear returns the block to ENTER_A with err=0.
REQ-034 Key 7 held for 100 cycles: exactly one key_evt and A=7. Direct change from 7 to 8 with no 16 between: no second event.
REQ-035 Chain 5,'*',3,'=','+',2,'=': disp_val=17. rst_n pulsed low during DIVIDE: all outputs return to reset values immediately.

Source files
------------

// File: rtl/calc_controller_pkg.sv
// Shared definitions for the calculator controller slice.
//   - key_t / KEY_*   : debounced keypad codes (0-9 are digits)
//   - state_t         : controller FSM state encoding
//   - op_t            : latched operator encoding (visible on op_pending)
//   - DIV_W           : width of the iterative divider (one quotient bit per cycle)
//   - small key classification helpers
package calc_controller_pkg;

    typedef logic [5:0] key_t;

    localparam key_t KEY_ADD  = 6'd10;
    localparam key_t KEY_SUB  = 6'd11;
    localparam key_t KEY_EQ   = 6'd12;
    localparam key_t KEY_MUL  = 6'd13;
    localparam key_t KEY_CLR  = 6'd14;
    localparam key_t KEY_DIV  = 6'd15;
    localparam key_t KEY_NONE = 6'd16;

    localparam int DIV_W = 16;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_DIVIDE  = 3'd2,
        ST_SHOW    = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    function automatic logic is_digit(input key_t code);
        return code <= 6'd9;
    endfunction

    function automatic logic is_operator(input key_t code);
        return (code == KEY_ADD) || (code == KEY_SUB) ||
               (code == KEY_MUL) || (code == KEY_DIV);
    endfunction

    function automatic op_t key_to_op(input key_t code);
        case (code)
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            KEY_DIV: return OP_DIV;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_controller_if.sv
// Keypad / display bundle of the calculator controller.
//   key_code   : debounced key code into the controller
//   disp_val   : registered unsigned value to display
//   op_pending : latched operator (op_t encoding)
//   busy       : iterative divide in progress
//   err        : controller is in its error state
//   key_evt    : one-cycle pulse per key event
// master = keypad/display side, slave = controller.
interface calc_controller_if
    import calc_controller_pkg::*;
#(
    parameter int RW = 27
);
    key_t          key_code;
    logic [RW-1:0] disp_val;
    logic [1:0]    op_pending;
    logic          busy;
    logic          err;
    logic          key_evt;

    modport master (
        output key_code,
        input  disp_val, op_pending, busy, err, key_evt
    );

    modport slave (
        input  key_code,
        output disp_val, op_pending, busy, err, key_evt
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse; dividend/divisor sampled on this cycle
//   dividend   : W-bit numerator
//   divisor    : W-bit denominator (caller guarantees non-zero)
//   done       : one-cycle pulse, quotient valid from this cycle on
//   quotient   : floor(dividend / divisor)
// The first quotient bit is produced on the start edge itself, so done
// rises exactly W cycles after start.
module seq_divider
    import calc_controller_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient
);
    localparam int CW = $clog2(W + 1);

    logic [W:0]    rem;
    logic [W-1:0]  quo;
    logic [W-1:0]  dvs;
    logic [CW-1:0] cnt;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, subtract when it fits. Returns {remainder, quotient}.
    // Because the remainder is always below the divisor, bit W of the
    // difference is a reliable "did not fit" flag.
    function automatic logic [2*W:0] div_step(input logic [W:0]   r,
                                              input logic [W-1:0] q,
                                              input logic [W-1:0] d);
        logic [W:0] sh;
        logic [W:0] diff;
        sh   = {r[W-1:0], q[W-1]};
        diff = sh - {1'b0, d};
        if (diff[W])
            return {sh, q[W-2:0], 1'b0};
        else
            return {diff, q[W-2:0], 1'b1};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                {rem, quo} <= div_step({(W+1){1'b0}}, dividend, divisor);
                dvs        <= divisor;
                cnt        <= CW'(W - 1);
            end else if (cnt != '0) begin
                {rem, quo} <= div_step(rem, quo, dvs);
                cnt        <= cnt - CW'(1);
                if (cnt == CW'(1))
                    done <= 1'b1;
            end
        end
    end

    assign quotient = quo;

endmodule

// File: rtl/calc_controller.sv
// Four-function keypad calculator controller.
//   clk, rst_n : 12 MHz clock, asynchronous active-low reset
//   bus        : calc_controller_if slave (key_code in; disp_val,
//                op_pending, busy, err, key_evt out)
// Stage p0 turns the raw key code into a single event pulse (press after
// a released/no-key cycle). The FSM consumes that event in the following
// cycle, so every output is registered one cycle behind key_evt.
module calc_controller
    import calc_controller_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int RW     = 27
) (
    input  logic              clk,
    input  logic              rst_n,
    calc_controller_if.slave  bus
);
    // Operand width: just enough for DIGITS decimal digits.
    localparam int            OW      = $clog2(10**DIGITS);
    localparam logic [RW-1:0] POW10   = RW'(10**DIGITS);
    // An operand below this still has room for one more digit; this also
    // makes leading zeros free since a zero operand never reaches it.
    localparam logic [OW-1:0] DIG_LIM = OW'(10**(DIGITS-1));

    key_t          prev_code;
    logic          key_evt_p0;

    state_t        state;
    op_t           op;
    logic [OW-1:0] a;
    logic [OW-1:0] b;
    logic [RW-1:0] result;
    logic [RW-1:0] disp;
    logic          busy_r;
    logic          err_r;

    logic              div_start;
    logic              div_done;
    logic [DIV_W-1:0]  div_q;

    function automatic logic [OW-1:0] acc_digit(input logic [OW-1:0] opnd,
                                                input logic [3:0]    dig);
        return OW'({4'd0, opnd} * (OW+4)'(10) + (OW+4)'(dig));
    endfunction

    // ---- stage p0: key event detect ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_code  <= KEY_NONE;
            key_evt_p0 <= 1'b0;
        end else begin
            prev_code  <= bus.key_code;
            key_evt_p0 <= (bus.key_code != KEY_NONE) && (prev_code == KEY_NONE);
        end
    end

    // While key_evt_p0 is high, prev_code holds the code that caused it.
    // The start pulse is decoded from the same condition the FSM uses to
    // enter DIVIDE, so the divider's 16 cycles line up with busy.
    assign div_start = key_evt_p0 && (state == ST_ENTER_B) &&
                       (prev_code == KEY_EQ) && (op == OP_DIV) && (b != '0);

    seq_divider #(.W(DIV_W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (DIV_W'(a)),
        .divisor  (DIV_W'(b)),
        .done     (div_done),
        .quotient (div_q)
    );

    // ---- stage p1: controller FSM and registered outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_ENTER_A;
            op     <= OP_ADD;
            a      <= '0;
            b      <= '0;
            result <= '0;
            disp   <= '0;
            busy_r <= 1'b0;
            err_r  <= 1'b0;
        end else if (state == ST_DIVIDE) begin
            // Keys, including clear, are not looked at until the divide ends.
            if (div_done) begin
                result <= RW'(div_q);
                disp   <= RW'(div_q);
                busy_r <= 1'b0;
                state  <= ST_SHOW;
            end
        end else if (key_evt_p0) begin
            if (prev_code == KEY_CLR) begin
                a      <= '0;
                b      <= '0;
                result <= '0;
                op     <= OP_ADD;
                disp   <= '0;
                err_r  <= 1'b0;
                state  <= ST_ENTER_A;
            end else begin
                case (state)
                    ST_ENTER_A: begin
                        if (is_digit(prev_code)) begin
                            if (a < DIG_LIM) begin
                                a    <= acc_digit(a, prev_code[3:0]);
                                disp <= RW'(acc_digit(a, prev_code[3:0]));
                            end
                        end else if (is_operator(prev_code)) begin
                            op    <= key_to_op(prev_code);
                            b     <= '0;
                            disp  <= '0;
                            state <= ST_ENTER_B;
                        end else if (prev_code == KEY_EQ) begin
                            result <= RW'(a);
                            disp   <= RW'(a);
                            state  <= ST_SHOW;
                        end
                    end
                    ST_ENTER_B: begin
                        if (is_digit(prev_code)) begin
                            if (b < DIG_LIM) begin
                                b    <= acc_digit(b, prev_code[3:0]);
                                disp <= RW'(acc_digit(b, prev_code[3:0]));
                            end
                        end else if (is_operator(prev_code)) begin
                            op <= key_to_op(prev_code);
                        end else if (prev_code == KEY_EQ) begin
                            case (op)
                                OP_ADD: begin
                                    result <= RW'(a) + RW'(b);
                                    disp   <= RW'(a) + RW'(b);
                                    state  <= ST_SHOW;
                                end
                                OP_SUB: begin
                                    if (a < b) begin
                                        disp  <= '0;
                                        err_r <= 1'b1;
                                        state <= ST_ERROR;
                                    end else begin
                                        result <= RW'(a) - RW'(b);
                                        disp   <= RW'(a) - RW'(b);
                                        state  <= ST_SHOW;
                                    end
                                end
                                OP_MUL: begin
                                    result <= RW'(a) * RW'(b);
                                    disp   <= RW'(a) * RW'(b);
                                    state  <= ST_SHOW;
                                end
                                default: begin
                                    if (b == '0) begin
                                        disp  <= '0;
                                        err_r <= 1'b1;
                                        state <= ST_ERROR;
                                    end else begin
                                        // disp keeps showing B while dividing
                                        busy_r <= 1'b1;
                                        state  <= ST_DIVIDE;
                                    end
                                end
                            endcase
                        end
                    end
                    ST_SHOW: begin
                        if (is_digit(prev_code)) begin
                            a     <= OW'(prev_code[3:0]);
                            disp  <= RW'(prev_code[3:0]);
                            state <= ST_ENTER_A;
                        end else if (is_operator(prev_code)) begin
                            if (result < POW10) begin
                                a     <= OW'(result);
                                b     <= '0;
                                op    <= key_to_op(prev_code);
                                disp  <= '0;
                                state <= ST_ENTER_B;
                            end else begin
                                disp  <= '0;
                                err_r <= 1'b1;
                                state <= ST_ERROR;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.disp_val   = disp;
    assign bus.op_pending = op;
    assign bus.busy       = busy_r;
    assign bus.err        = err_r;
    assign bus.key_evt    = key_evt_p0;

endmodule

// File: tb/tb_calc_controller.sv
// Scoreboard bench for calc_controller: each key press pushes the expected
// display/err/op/busy state; a monitor pops and compares one cycle after
// every key_evt seen while not busy, and again when busy falls.
module tb_calc_controller;
    import calc_controller_pkg::*;

    localparam int RW = 27;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    calc_controller_if #(.RW(RW)) bus ();

    calc_controller #(.DIGITS(4), .RW(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [RW-1:0] disp;
        logic          err;
        logic [1:0]    op;
        logic          busy;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   evt_cnt  = 0;
    int   busy_len = 0;
    logic pend      = 1'b0;
    logic prev_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic compare_top();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_output: got disp %0d with no expectation queued", bus.disp_val);
        end else begin
            e = sb.pop_front();
            check("disp_val",   32'(bus.disp_val),   32'(e.disp));
            check("err",        32'(bus.err),        32'(e.err));
            check("op_pending", 32'(bus.op_pending), 32'(e.op));
            check("busy",       32'(bus.busy),       32'(e.busy));
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            pend      = 1'b0;
            prev_busy = 1'b0;
            busy_len  = 0;
        end else begin
            if (bus.key_evt) evt_cnt++;
            if (pend) begin
                pend = 1'b0;
                compare_top();
            end
            if (bus.busy) busy_len++;
            if (prev_busy && !bus.busy) begin
                check("busy_cycles", 32'(busy_len), 32'd16);
                busy_len = 0;
                compare_top();
            end
            if (bus.key_evt && !bus.busy) pend = 1'b1;
            prev_busy = bus.busy;
        end
    end

    task automatic push(input int d, input logic e, input int o, input logic b);
        exp_t x;
        x.disp = RW'(d);
        x.err  = e;
        x.op   = 2'(o);
        x.busy = b;
        sb.push_back(x);
    endtask

    task automatic press(input int k);
        @(posedge clk); #1 bus.key_code = 6'(k);
        repeat (3) @(posedge clk);
        #1 bus.key_code = KEY_NONE;
        repeat (3) @(posedge clk);
    endtask

    // press a key and expect the given display / operator, no error
    task automatic pk(input int k, input int d, input int o);
        push(d, 1'b0, o, 1'b0);
        press(k);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && (sb.size() != 0 || pend); i++) @(posedge clk);
        check(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_not_busy();
        for (int i = 0; i < 100 && bus.busy; i++) @(posedge clk);
        check("div_finish", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int e0;
        bus.key_code = KEY_NONE;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_disp",    32'(bus.disp_val),   32'd0);
        check("rst_op",      32'(bus.op_pending), 32'd0);
        check("rst_busy",    32'(bus.busy),       32'd0);
        check("rst_err",     32'(bus.err),        32'd0);
        check("rst_key_evt", 32'(bus.key_evt),    32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 12 + 34 = 46, then '=' in SHOW ignored
        e0 = evt_cnt;
        pk(1, 1, 0); pk(2, 12, 0); pk(KEY_ADD, 0, 0);
        pk(3, 3, 0); pk(4, 34, 0); pk(KEY_EQ, 46, 0);
        drain("drain_add");
        check("evt_count_add", 32'(evt_cnt - e0), 32'd6);
        pk(KEY_EQ, 46, 0);
        pk(KEY_CLR, 0, 0);

        // leading zeros do not count, fifth real digit dropped
        pk(0, 0, 0); pk(0, 0, 0); pk(1, 1, 0); pk(2, 12, 0);
        pk(3, 123, 0); pk(4, 1234, 0); pk(5, 1234, 0);
        pk(KEY_CLR, 0, 0);

        // 9999 * 9999, then operator on an oversize result -> error
        pk(9, 9, 0); pk(9, 99, 0); pk(9, 999, 0); pk(9, 9999, 0); pk(9, 9999, 0);
        pk(KEY_MUL, 0, 2);
        pk(9, 9, 2); pk(9, 99, 2); pk(9, 999, 2); pk(9, 9999, 2);
        pk(KEY_EQ, 99980001, 2);
        push(0, 1'b1, 2, 1'b0); press(KEY_ADD);
        pk(KEY_CLR, 0, 0);

        // 100 / 7 = 14, key 5 during busy ignored
        pk(1, 1, 0); pk(0, 10, 0); pk(0, 100, 0);
        pk(KEY_DIV, 0, 3); pk(7, 7, 3);
        push(7, 1'b0, 3, 1'b1);
        push(14, 1'b0, 3, 1'b0);
        press(KEY_EQ);
        press(5);
        wait_not_busy();
        drain("drain_div");
        check("div_result_kept", 32'(bus.disp_val), 32'd14);
        pk(KEY_CLR, 0, 0);

        // divide by zero, clear, underflowing subtract, digit ignored in error
        pk(5, 5, 0); pk(KEY_DIV, 0, 3); pk(0, 0, 3);
        push(0, 1'b1, 3, 1'b0); press(KEY_EQ);
        pk(KEY_CLR, 0, 0);
        pk(3, 3, 0); pk(KEY_SUB, 0, 1); pk(8, 8, 1);
        push(0, 1'b1, 1, 1'b0); press(KEY_EQ);
        push(0, 1'b1, 1, 1'b0); press(4);
        pk(KEY_CLR, 0, 0);
        pk(4, 4, 0);
        pk(KEY_CLR, 0, 0);
        drain("drain_err");

        // held key and direct code change
        e0 = evt_cnt;
        push(7, 1'b0, 0, 1'b0);
        @(posedge clk); #1 bus.key_code = 6'd7;
        repeat (100) @(posedge clk);
        #1 bus.key_code = 6'd8;
        repeat (5) @(posedge clk);
        #1 bus.key_code = KEY_NONE;
        repeat (3) @(posedge clk);
        drain("drain_hold");
        check("evt_count_hold", 32'(evt_cnt - e0), 32'd1);
        check("hold_disp", 32'(bus.disp_val), 32'd7);
        pk(KEY_CLR, 0, 0);

        // chained: 5*3=15, +2 = 17
        pk(5, 5, 0); pk(KEY_MUL, 0, 2); pk(3, 3, 2); pk(KEY_EQ, 15, 2);
        pk(KEY_ADD, 0, 0); pk(2, 2, 0); pk(KEY_EQ, 17, 0);
        pk(KEY_CLR, 0, 0);

        // reset during divide
        pk(9, 9, 0); pk(9, 99, 0); pk(KEY_DIV, 0, 3); pk(3, 3, 3);
        push(3, 1'b0, 3, 1'b1); press(KEY_EQ);
        drain("drain_pre_rst");
        check("busy_before_rst", 32'(bus.busy), 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("rst_mid_disp",    32'(bus.disp_val),   32'd0);
        check("rst_mid_op",      32'(bus.op_pending), 32'd0);
        check("rst_mid_busy",    32'(bus.busy),       32'd0);
        check("rst_mid_err",     32'(bus.err),        32'd0);
        check("rst_mid_key_evt", 32'(bus.key_evt),    32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("post_rst_busy", 32'(bus.busy),     32'd0);
        check("post_rst_disp", 32'(bus.disp_val), 32'd0);
        drain("drain_final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
